// File: rtl/lifo_stack_mem.sv
// LIFO stack with a registered top-of-stack output, occupancy count, level flags
// and sticky overflow/underflow error flags.
module lifo_stack_mem #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 8,
    parameter  int AF_LEVEL = DEPTH - 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             wr_en;
    logic [AW-1:0]    wr_idx;

    logic             is_empty;
    logic             is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        count_d     = count_q;
        dout_d      = dout_q;
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        wr_en       = 1'b0;
        wr_idx      = '0;

        // A new error in the same cycle as clr_err wins because it is assigned last.
        unique case ({push, pop})
            2'b10: begin
                if (!is_full) begin
                    wr_en   = 1'b1;
                    wr_idx  = AW'(count_q);
                    count_d = count_q + CW'(1);
                    dout_d  = din;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    count_d = count_q - CW'(1);
                    dout_d  = (count_q >= CW'(2)) ? mem[AW'(count_q - CW'(2))] : '0;
                end else begin
                    underflow_d = 1'b1;
                end
            end
            2'b11: begin
                wr_en  = 1'b1;
                dout_d = din;
                if (is_empty) begin
                    wr_idx      = '0;
                    count_d     = CW'(1);
                    underflow_d = 1'b1;
                end else begin
                    wr_idx = AW'(count_q - CW'(1));
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset; stale words are never visible because count bounds every read.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_idx] <= din;
        end
    end

    assign dout        = dout_q;
    assign count       = count_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count_q >= CW'(AF_LEVEL));
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_lifo_stack_mem.sv
// Directed, table-driven bench for lifo_stack_mem with WIDTH=8, DEPTH=4, AF_LEVEL=3.
module tb_lifo_stack_mem;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             empty, full, almost_full, overflow, underflow;

    int errors = 0;
    int checks = 0;

    lifo_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .din         (din),
        .clr_err     (clr_err),
        .dout        (dout),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown({push, pop})) else $error("push/pop unknown outside reset");
        end
    end

    typedef struct {
        logic       rst, psh, pp;
        logic [7:0] d;
        logic       clr;
        logic [2:0] e_cnt;
        logic [7:0] e_dout;
        logic       e_empty, e_full, e_af, e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic rst, psh, pp, input logic [7:0] d, input logic clr,
                     input logic [2:0] c, input logic [7:0] o,
                     input logic e, f, af, ov, un);
        vec_t t;
        t = '{rst, psh, pp, d, clr, c, o, e, f, af, ov, un};
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, psh, pp, input logic [7:0] d, input logic clr);
        reset   = rst;
        push    = psh;
        pop     = pp;
        din     = d;
        clr_err = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [2:0] c, input logic [7:0] o,
                             input logic e, f, af, ov, un);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".dout"}, 32'(dout), 32'(o));
        check({tag, ".empty"}, 32'(empty), 32'(e));
        check({tag, ".full"}, 32'(full), 32'(f));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        check({tag, ".overflow"}, 32'(overflow), 32'(ov));
        check({tag, ".underflow"}, 32'(underflow), 32'(un));
    endtask

    initial begin
        //  rst psh pop din    clr   cnt dout   e  f  af ov un
        v(1, 1, 0, 8'hAA, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        v(1, 1, 0, 8'hAA, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        v(0, 1, 0, 8'h11, 0, 1, 8'h11, 0, 0, 0, 0, 0);
        v(0, 1, 0, 8'h22, 0, 2, 8'h22, 0, 0, 0, 0, 0);
        v(0, 1, 0, 8'h33, 0, 3, 8'h33, 0, 0, 1, 0, 0);
        v(0, 1, 0, 8'h44, 0, 4, 8'h44, 0, 1, 1, 0, 0);
        v(0, 1, 0, 8'h55, 0, 4, 8'h44, 0, 1, 1, 1, 0);
        v(0, 0, 1, 8'h00, 0, 3, 8'h33, 0, 0, 1, 1, 0);
        v(0, 0, 1, 8'h00, 0, 2, 8'h22, 0, 0, 0, 1, 0);
        v(0, 0, 1, 8'h00, 0, 1, 8'h11, 0, 0, 0, 1, 0);
        v(0, 0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 1, 0);
        v(0, 0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 1, 1);
        v(0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 0);
        v(0, 1, 0, 8'h10, 0, 1, 8'h10, 0, 0, 0, 0, 0);
        v(0, 1, 1, 8'h99, 0, 1, 8'h99, 0, 0, 0, 0, 0);
        v(0, 0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        v(0, 1, 0, 8'h01, 0, 1, 8'h01, 0, 0, 0, 0, 0);
        v(0, 1, 0, 8'h02, 0, 2, 8'h02, 0, 0, 0, 0, 0);
        v(0, 1, 0, 8'h03, 0, 3, 8'h03, 0, 0, 1, 0, 0);
        v(0, 1, 0, 8'h04, 0, 4, 8'h04, 0, 1, 1, 0, 0);
        v(0, 1, 1, 8'h77, 0, 4, 8'h77, 0, 1, 1, 0, 0);
        v(0, 0, 1, 8'h00, 0, 3, 8'h03, 0, 0, 1, 0, 0);
        v(0, 0, 1, 8'h00, 0, 2, 8'h02, 0, 0, 0, 0, 0);
        v(0, 0, 1, 8'h00, 0, 1, 8'h01, 0, 0, 0, 0, 0);
        v(0, 0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        v(0, 1, 1, 8'h5A, 0, 1, 8'h5A, 0, 0, 0, 0, 1);
        v(0, 0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 1);
        v(0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].psh, vecs[i].pp, vecs[i].d, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_dout, vecs[i].e_empty,
                      vecs[i].e_full, vecs[i].e_af, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Sticky overflow against clr_err, then reset mid-sequence with a push pending.
        for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, 8'(8'hA0 + i), 0);
        check_all("fill", 4, 8'hA4, 0, 1, 1, 0, 0);
        step(0, 1, 0, 8'hA5, 0);
        check_all("ovf_set", 4, 8'hA4, 0, 1, 1, 1, 0);
        step(0, 1, 0, 8'hA6, 1);
        check_all("ovf_clr_vs_new", 4, 8'hA4, 0, 1, 1, 1, 0);
        step(0, 0, 0, 8'h00, 1);
        check_all("ovf_clr", 4, 8'hA4, 0, 1, 1, 0, 0);
        step(0, 0, 1, 8'h00, 0);
        step(0, 0, 1, 8'h00, 0);
        check_all("pop_to_2", 2, 8'hA2, 0, 0, 0, 0, 0);
        step(1, 1, 0, 8'hFF, 0);
        check_all("mid_reset", 0, 8'h00, 1, 0, 0, 0, 0);
        step(0, 0, 1, 8'h00, 1);
        check_all("unf_clr_vs_new", 0, 8'h00, 1, 0, 0, 0, 1);
        step(0, 1, 0, 8'hC3, 0);
        check_all("push_after_reset", 1, 8'hC3, 0, 0, 0, 0, 1);
        step(0, 0, 0, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lifo_stack_mem.md
Name: lifo_stack_mem

Overview:
Parametrised LIFO stack memory with a registered top-of-stack output, occupancy count, full/empty/almost-full flags and sticky overflow/underflow error flags. It supersedes the fixed 8-bit memory with its hand-decoded word lines and pointer. Width, depth and the almost-full threshold are generics. It sits between a datapath producer/consumer pair and is driven by single-cycle push/pop strobes.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of stack entries (>=2)
AF_LEVEL, DEPTH-1, count at or above which almost_full asserts (1..DEPTH)
CW, $clog2(DEPTH+1), count width (derived, do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
push  input  1  push strobe, sampled each rising edge
pop  input  1  pop strobe, sampled each rising edge
din  input  WIDTH  data to push
clr_err  input  1  clears sticky error flags
dout  output  WIDTH  registered top-of-stack value; 0 when empty
count  output  CW  current number of stored entries
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_LEVEL
overflow  output  1  sticky: push attempted while full without pop
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (reset=1 at rising edge): count=0, internal pointer=0, dout=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0. Memory array contents are not cleared. Reset overrides every other input in the same cycle, including a push/pop in progress.
- Flags empty/full/almost_full are decoded from the registered count. They are valid in the same cycle as count.
- Operations, decoded from {push,pop} at each edge:
  - 00 idle: no change.
  - 10 push, not full: mem[count] <= din; count+1; dout <= din.
  - 10 push, full: ignored; overflow <= 1; count and dout unchanged.
  - 01 pop, not empty: count-1; dout <= mem[count-2] if count>=2, else 0.
  - 01 pop, empty: ignored; underflow <= 1.
  - 11 replace, not empty: mem[count-1] <= din; dout <= din; count unchanged. Neither error flag is set, even when full.
  - 11 on empty: behaves as a push of din (count becomes 1, dout=din); underflow <= 1.
- Latency: dout, count and flags reflect an operation one edge after it is sampled. No combinational path from push/pop/din to any output.
- dout after pop comes from the registered read of the new top, so it is valid the cycle after the pop edge. No bubble.
- Error flags: once set, they stay set until clr_err=1 or reset. If clr_err and a new error occur in the same cycle, the new error wins (flag ends at 1).
- Count arithmetic is unsigned CW bits and never wraps. It saturates at 0 and DEPTH by rule, not by wrap.
- Pointer wrap is not permitted: writes only target indices 0..DEPTH-1.
- X on push/pop outside reset is illegal. The bench flags it with an assertion.

Test Plan:
1. WIDTH=8, DEPTH=4: reset, then check count=0, empty=1, dout=0, all errors 0. Hold reset with push=1 and din=8'hAA -> state unchanged.
2. Push 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles -> count steps 1,2,3,4; dout=8'h44; full=1; almost_full=1 from count=3 (AF_LEVEL=3). A fifth push of 8'h55 -> overflow=1, count=4, dout=8'h44.
3. From full, pop four times -> dout sequence 8'h33, 8'h22, 8'h11, 8'h00; empty=1. A fifth pop -> underflow=1, count=0.
4. Push 8'h10, then push+pop with din=8'h99 -> count=1, dout=8'h99, no error. Then pop -> empty, dout=0.
5. On full stack, push+pop with din=8'h77 -> count=4, dout=8'h77, overflow stays 0. On empty stack, push+pop with din=8'h5A -> count=1, dout=8'h5A, underflow=1.
6. With overflow=1, assert clr_err together with an overflowing push -> overflow stays 1. Next cycle, clr_err alone -> overflow=0. Assert reset mid-sequence at count=2 -> count=0, dout=0 on the next edge.
